// File: rtl/ask_tx_scheduler.sv
// Round-robin grant of two valid/ready requesters onto one 2ASK modulator; words go out MSB-first, SYM_CYCLES clocks per bit.
// Optional macro ASK_TX_PREAMBLE_EN sends a PREAMBLE word before every payload.
module ask_tx_scheduler #(
    parameter int SYM_CYCLES = 50,
    parameter int DATA_W     = 16
`ifdef ASK_TX_PREAMBLE_EN
    ,
    parameter logic [DATA_W-1:0] PREAMBLE = 16'hAAAA
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] mod_data,
    output logic              mod_bit,
    output logic              mod_en,
    output logic              sym_stb,
    output logic              grant_id,
    output logic              busy,
    output logic              done
);
    localparam int CW = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SYM_CYCLES - 1);
    localparam logic [BW-1:0] IDX_TOP  = BW'(DATA_W - 1);

`ifdef ASK_TX_PREAMBLE_EN
    typedef enum logic [1:0] {IDLE, PRE, SEND} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t            state, state_n;
    logic [CW-1:0]     sym_cnt, cnt_n, adv_cnt;
    logic [BW-1:0]     bit_idx, idx_n, adv_idx;
    logic [DATA_W-1:0] data_n;
    logic              last_grant;
    logic              grant;
    logic              hs;
    logic              frame_end;
    logic              done_n;
`ifdef ASK_TX_PREAMBLE_EN
    logic [DATA_W-1:0] payload, payload_n;
`endif

    // Tie goes to whoever did not win last; a lone requester always wins.
    assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = !sys_rst && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = !sys_rst && (state == IDLE) && req1_valid && grant;
    assign hs         = req0_ready || req1_ready;
    assign frame_end  = (sym_cnt == CNT_LAST) && (bit_idx == '0);

    always_comb begin
        adv_cnt = sym_cnt + 1'b1;
        adv_idx = bit_idx;
        if (sym_cnt == CNT_LAST) begin
            adv_cnt = '0;
            adv_idx = bit_idx - 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = sym_cnt;
        idx_n   = bit_idx;
        data_n  = mod_data;
`ifdef ASK_TX_PREAMBLE_EN
        payload_n = payload;
`endif
        case (state)
            IDLE: begin
                if (hs) begin
                    cnt_n = '0;
                    idx_n = IDX_TOP;
`ifdef ASK_TX_PREAMBLE_EN
                    state_n   = PRE;
                    data_n    = PREAMBLE;
                    payload_n = grant ? req1_data : req0_data;
`else
                    state_n = SEND;
                    data_n  = grant ? req1_data : req0_data;
`endif
                end
            end
`ifdef ASK_TX_PREAMBLE_EN
            PRE: begin
                if (frame_end) begin
                    state_n = SEND;
                    cnt_n   = '0;
                    idx_n   = IDX_TOP;
                    data_n  = payload;
                end else begin
                    cnt_n = adv_cnt;
                    idx_n = adv_idx;
                end
            end
`endif
            SEND: begin
                if (frame_end) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = adv_cnt;
                    idx_n = adv_idx;
                end
            end
            default: state_n = IDLE;
        endcase
        // Outputs are registered, so they are derived from the next-cycle state.
        done_n = (state_n == SEND) && (cnt_n == CNT_LAST) && (idx_n == '0);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            sym_cnt    <= '0;
            bit_idx    <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            mod_data   <= '0;
            mod_bit    <= 1'b0;
            mod_en     <= 1'b0;
            sym_stb    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef ASK_TX_PREAMBLE_EN
            payload    <= '0;
`endif
        end else begin
            state    <= state_n;
            sym_cnt  <= cnt_n;
            bit_idx  <= idx_n;
            mod_data <= data_n;
            mod_bit  <= data_n[idx_n];
            mod_en   <= (state_n != IDLE);
            busy     <= (state_n != IDLE);
            sym_stb  <= (state_n != IDLE) && (cnt_n == '0);
            done     <= done_n;
`ifdef ASK_TX_PREAMBLE_EN
            payload  <= payload_n;
`endif
            if (hs) begin
                grant_id   <= grant;
                last_grant <= grant;
            end
        end
    end
endmodule
